// File: rtl/truth_sweep_pkg.sv
// -----------------------------------------------------------------------------
// truth_sweep_pkg
// Shared types and helpers for the truth_table_sweeper block.
//   state_t     : sweeper FSM states (IDLE, SWEEP, DONE)
//   MAX_N_IN    : largest supported number of function inputs
//   MAX_MASK_W  : term-mask width at MAX_N_IN
//   term_value  : f(idx) = mask[idx] XOR mode, used by the lookup and stream paths
// -----------------------------------------------------------------------------
package truth_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int MAX_N_IN   = 6;
  localparam int MAX_MASK_W = 1 << MAX_N_IN;

  // mode = 0: listed terms are minterms (give 1); mode = 1: listed terms are
  // maxterms (give 0). Callers zero-extend narrower masks/indices.
  function automatic logic term_value(input logic [MAX_MASK_W-1:0] mask,
                                      input logic [MAX_N_IN-1:0]   idx,
                                      input logic                  mode);
    return mask[idx] ^ mode;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper_if
// Command, lookup and stream signals of the truth_table_sweeper.
//   master : the user side (drives load/mask_in/mode/start/eval_in/out_ready)
//   slave  : the sweeper (drives eval_out, stream beat, busy/done, ones_count)
// Parameter N_IN: number of function inputs (1..6).
// -----------------------------------------------------------------------------
interface truth_table_sweeper_if #(
  parameter int N_IN = 3
) ();
  logic                   load;
  logic [(1<<N_IN)-1:0]   mask_in;
  logic                   mode;
  logic                   start;
  logic [N_IN-1:0]        eval_in;
  logic                   eval_out;
  logic                   out_valid;
  logic                   out_ready;
  logic [N_IN-1:0]        out_idx;
  logic                   out_bit;
  logic                   busy;
  logic                   done;
  logic [N_IN:0]          ones_count;

  modport master (
    output load, mask_in, mode, start, eval_in, out_ready,
    input  eval_out, out_valid, out_idx, out_bit, busy, done, ones_count
  );

  modport slave (
    input  load, mask_in, mode, start, eval_in, out_ready,
    output eval_out, out_valid, out_idx, out_bit, busy, done, ones_count
  );
endinterface

// File: rtl/truth_lut.sv
// -----------------------------------------------------------------------------
// truth_lut
// Holds the term mask and mode registers and evaluates the function.
//   clk, rst       : clock, synchronous active-high reset
//   i_we           : write mask/mode (qualified by the FSM: IDLE only)
//   i_mask, i_mode : new term mask / mode (0 = SoP, 1 = PoS)
//   i_eval_in      : lookup input -> o_eval_out, registered (1-cycle latency)
//   i_stream_idx   : sweep index  -> o_stream_bit, combinational from registers
// -----------------------------------------------------------------------------
module truth_lut
  import truth_sweep_pkg::*;
#(
  parameter int N_IN = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_we,
  input  logic [(1<<N_IN)-1:0] i_mask,
  input  logic                 i_mode,
  input  logic [N_IN-1:0]      i_eval_in,
  input  logic [N_IN-1:0]      i_stream_idx,
  output logic                 o_eval_out,
  output logic                 o_stream_bit
);

  logic [(1<<N_IN)-1:0]  r_mask;
  logic                  r_mode;
  logic                  r_eval_out;
  logic [MAX_MASK_W-1:0] w_mask_ext;

  assign w_mask_ext = MAX_MASK_W'(r_mask);

  // NOTE: the mask is a small register bank, not a RAM, so it is reset; this
  // makes f identically 0 after rst instead of leaving it undefined.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask     <= '0;
      r_mode     <= 1'b0;
      r_eval_out <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so the lookup below sees the mask as it
      // was before a write on this same edge.
      if (i_we) begin
        r_mask <= i_mask;
        r_mode <= i_mode;
      end
      r_eval_out <= term_value(w_mask_ext, MAX_N_IN'(i_eval_in), r_mode);
    end
  end

  assign o_eval_out   = r_eval_out;
  assign o_stream_bit = term_value(w_mask_ext, MAX_N_IN'(i_stream_idx), r_mode);

endmodule

// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
// Programmable N_IN-input Boolean function with a truth-table sweep stream.
//   clk, rst : clock, synchronous active-high reset
//   bus      : truth_table_sweeper_if.slave (commands, lookup, stream, status)
// Build option TRUTH_SWEEP_COUNT_EN: when defined, ones_count accumulates the
// number of 1 beats of the last sweep; when undefined it is tied to 0.
// -----------------------------------------------------------------------------
module truth_table_sweeper
  import truth_sweep_pkg::*;
#(
  parameter int N_IN = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  truth_table_sweeper_if.slave   bus
);

  state_t          r_state;
  state_t          w_next_state;
  logic [N_IN-1:0] r_idx;
  logic            w_lut_we;
  logic            w_start_sweep;
  logic            w_xfer;
  logic            w_last;
  logic            w_stream_bit;
  logic [N_IN:0]   w_ones_count;

  truth_lut #(.N_IN(N_IN)) u_lut (
    .clk          (clk),
    .rst          (rst),
    .i_we         (w_lut_we),
    .i_mask       (bus.mask_in),
    .i_mode       (bus.mode),
    .i_eval_in    (bus.eval_in),
    .i_stream_idx (r_idx),
    .o_eval_out   (bus.eval_out),
    .o_stream_bit (w_stream_bit)
  );

  assign w_xfer = (r_state == SWEEP) && bus.out_ready;
  assign w_last = &r_idx;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    w_next_state  = r_state;
    w_lut_we      = 1'b0;
    w_start_sweep = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_lut_we      = bus.load;
        w_start_sweep = bus.start;
        if (bus.start) w_next_state = SWEEP;
      end
      SWEEP:   if (w_xfer && w_last) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // The index wraps to 0 on the final transfer, ready for the next sweep.
  always_ff @(posedge clk) begin
    if (rst)                r_idx <= '0;
    else if (w_start_sweep) r_idx <= '0;
    else if (w_xfer)        r_idx <= r_idx + 1'b1;
  end

`ifdef TRUTH_SWEEP_COUNT_EN
  logic [N_IN:0] r_ones_count;

  // At most 2^N_IN beats of one bit each, so N_IN+1 bits cannot overflow.
  always_ff @(posedge clk) begin
    if (rst)                r_ones_count <= '0;
    else if (w_start_sweep) r_ones_count <= '0;
    else if (w_xfer)        r_ones_count <= r_ones_count + {{N_IN{1'b0}}, w_stream_bit};
  end

  assign w_ones_count = r_ones_count;
`else
  assign w_ones_count = '0;
`endif

  assign bus.out_valid  = (r_state == SWEEP);
  assign bus.out_idx    = r_idx;
  assign bus.out_bit    = (r_state == SWEEP) & w_stream_bit;
  assign bus.busy       = (r_state != IDLE);
  assign bus.done       = (r_state == DONE);
  assign bus.ones_count = w_ones_count;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// tb_truth_table_sweeper
// Self-checking bench: a queue-based reference model of the truth table is
// compared against the DUT on every falling edge, and directed scenarios pin
// the model with hand-computed literal results.
// -----------------------------------------------------------------------------
module tb_truth_table_sweeper;

  localparam int N_IN  = 3;
  localparam int DEPTH = 1 << N_IN;
`ifdef TRUTH_SWEEP_COUNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  truth_table_sweeper_if #(.N_IN(N_IN)) bus ();

  truth_table_sweeper #(.N_IN(N_IN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DEPTH-1:0] m_mask = '0;
  bit               m_mode = 1'b0;
  bit               m_on   = 1'b0;
  bit               exp_q[$];      // beats of the current sweep not yet accepted
  bit               exp_done = 1'b0;
  int               exp_run  = 0;  // ones accepted in the current/last sweep
  bit               exp_eval = 1'b0;

  int               cyc = 0;
  int               done_cnt = 0;
  int               done_edge = 0;
  logic [DEPTH-1:0] obs_bits;

  function automatic bit fmodel(input int i);
    return m_mask[i] ^ m_mode;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_on) begin
      check("eval_out",   bus.eval_out,   exp_eval);
      check("out_valid",  bus.out_valid,  exp_q.size() != 0);
      check("busy",       bus.busy,       (exp_q.size() != 0) || exp_done);
      check("done",       bus.done,       exp_done);
      check("ones_count", bus.ones_count, CNT_ON ? exp_run : 0);
      if (exp_q.size() != 0) begin
        check("out_idx", bus.out_idx, DEPTH - exp_q.size());
        check("out_bit", bus.out_bit, exp_q[0]);
      end
    end
    if (bus.done) begin
      done_cnt++;
      done_edge = cyc;
    end
    if (bus.out_valid && bus.out_ready) obs_bits[bus.out_idx] = bus.out_bit;

    // predict the outputs after the coming rising edge
    if (rst) begin
      m_mask = '0; m_mode = 1'b0; exp_q.delete();
      exp_done = 1'b0; exp_run = 0; exp_eval = 1'b0; m_on = 1'b1;
    end else if (m_on) begin
      exp_eval = fmodel(int'(bus.eval_in));
      if (exp_done) begin
        exp_done = 1'b0;
      end else if (exp_q.size() != 0) begin
        if (bus.out_ready) begin
          exp_run += int'(exp_q.pop_front());
          if (exp_q.size() == 0) exp_done = 1'b1;
        end
      end else begin
        if (bus.load) begin
          m_mask = bus.mask_in;
          m_mode = bus.mode;
        end
        if (bus.start) begin
          exp_run = 0;
          for (int i = 0; i < DEPTH; i++) exp_q.push_back(fmodel(i));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue start (optionally with a load) and return the edge it was sampled on.
  task automatic kick(input bit with_load, input logic [DEPTH-1:0] mask,
                      input bit mode, output int edge_t);
    obs_bits     = '0;
    bus.load     = with_load;
    bus.mask_in  = mask;
    bus.mode     = mode;
    bus.start    = 1'b1;
    tick();
    edge_t       = cyc;
    bus.load     = 1'b0;
    bus.start    = 1'b0;
  endtask

  task automatic run_to_done(input bit toggle_ready, input int limit);
    int  seen;
    bit  ph;
    int  n;
    seen = done_cnt;
    ph   = 1'b1;
    n    = 0;
    while (done_cnt == seen && n < limit) begin
      bus.out_ready = toggle_ready ? ph : 1'b1;
      tick();
      ph = ~ph;
      n++;
    end
    if (done_cnt == seen) check("done_timeout", 1, 0);
    bus.out_ready = 1'b1;
    tick();
  endtask

  initial begin
    int e;
    int dc;
    bus.load = 1'b0; bus.mask_in = '0; bus.mode = 1'b0; bus.start = 1'b0;
    bus.eval_in = '0; bus.out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // reset state and lookups
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_idx",   bus.out_idx,   0);
    check("rst_out_bit",   bus.out_bit,   0);
    check("rst_busy",      bus.busy,      0);
    check("rst_ones",      bus.ones_count, 0);
    bus.eval_in = 3'b101; tick();
    check("rst_lookup", bus.eval_out, 0);
    bus.load = 1'b1; bus.mask_in = 8'h8E; bus.mode = 1'b1; bus.eval_in = 3'b000;
    tick();
    bus.load = 1'b0; bus.eval_in = 3'b100; tick();
    check("pos_lookup_100", bus.eval_out, 1);
    bus.eval_in = 3'b111; tick();
    check("pos_lookup_111", bus.eval_out, 0);

    // full-rate PoS sweep
    kick(1'b0, 8'h00, 1'b0, e);
    run_to_done(1'b0, 40);
    check("pos_stream",  obs_bits, 8'h71);
    check("pos_done_at", done_edge - e, DEPTH);
    check("pos_ones",    bus.ones_count, CNT_ON ? 4 : 0);

    // SoP sweep with back-pressure
    bus.load = 1'b1; bus.mask_in = 8'h8E; bus.mode = 1'b0; tick();
    bus.load = 1'b0;
    kick(1'b0, 8'h00, 1'b0, e);
    run_to_done(1'b1, 60);
    check("sop_stream",  obs_bits, 8'h8E);
    check("sop_done_at", done_edge - e, 2 * DEPTH - 1);
    check("sop_ones",    bus.ones_count, CNT_ON ? 4 : 0);

    // commands ignored mid-sweep
    kick(1'b0, 8'h00, 1'b0, e);
    tick(); tick();
    bus.load = 1'b1; bus.mask_in = 8'hFF; bus.mode = 1'b1; bus.start = 1'b1;
    tick();
    bus.load = 1'b0; bus.start = 1'b0;
    check("ign_busy", bus.busy, 1);
    run_to_done(1'b0, 40);
    check("ign_stream", obs_bits, 8'h8E);
    bus.eval_in = 3'b000; tick();
    check("ign_lookup_0", bus.eval_out, 0);
    bus.eval_in = 3'b001; tick();
    check("ign_lookup_1", bus.eval_out, 1);

    // simultaneous load and start
    kick(1'b1, 8'h01, 1'b0, e);
    run_to_done(1'b0, 40);
    check("ls_stream", obs_bits, 8'h01);
    check("ls_ones",   bus.ones_count, CNT_ON ? 1 : 0);

    // reset mid-sweep at idx 3
    kick(1'b0, 8'h00, 1'b0, e);
    tick(); tick(); tick();
    check("mid_idx", bus.out_idx, 3);
    dc  = done_cnt;
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_busy",  bus.busy, 0);
    tick(); tick();
    check("mid_rst_nodone", done_cnt, dc);
    kick(1'b0, 8'h00, 1'b0, e);
    run_to_done(1'b0, 40);
    check("cleared_stream", obs_bits, 8'h00);
    check("cleared_ones",   bus.ones_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Programmable N-input Boolean function unit for the combinational-logic lab designs. It holds a 2^N-bit term mask interpreted as a sum of minterms (SoP) or a product of maxterms (PoS), answers single lookups, and on command sweeps every input combination in order. During a sweep it streams the truth table out over a valid/ready handshake. It replaces fixed, hand-written per-function modules, and lets one bench generate and check any truth table.

## Interface
Parameters:
- N_IN, 3, number of function inputs; legal range 1..6; mask width is 2^N_IN.

Ports (clock and reset first):
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  mask write strobe.
- mask_in  in  2^N_IN  term list; bit i set means term i is listed.
- mode  in  1  0 = SoP (listed terms give 1), 1 = PoS (listed terms give 0).
- start  in  1  begin a sweep.
- eval_in  in  N_IN  lookup input, MSB = first variable (x).
- eval_out  out  1  registered f(eval_in).
- out_valid  out  1  stream beat valid.
- out_ready  in  1  consumer accepts the beat.
- out_idx  out  N_IN  input combination of the current beat.
- out_bit  out  1  f(out_idx).
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse at the end of a sweep.
- ones_count  out  N_IN+1  number of combinations with f = 1 in the last sweep.

## Operation
- Function definition: f(i) = mask[i] XOR mode_r.
  - mode_r is the mode register.
  - Example: PoS(1,2,3,7), mask = 8'h8E, mode = 1, gives the sequence 1,0,0,0,1,1,1,0.
- Mask and mode registers:
  - A write occurs when load = 1 in IDLE.
  - load is ignored in SWEEP and DONE.
- States: IDLE, SWEEP, DONE.
  - IDLE -> SWEEP on start; out_idx = 0 and ones_count is cleared.
  - SWEEP: a beat transfers when out_valid and out_ready are both high. On transfer, idx increments and ones_count adds out_bit.
  - SWEEP -> DONE when the beat at idx = 2^N_IN - 1 transfers.
  - DONE -> IDLE unconditionally after one cycle.
- start is ignored outside IDLE.
- load and start in the same IDLE cycle: the new mask and mode are written, and the sweep uses the new values.
- Lookup path is independent of state and is valid at all times, including during a sweep.
- Reset values:
  - state = IDLE; mask = 0; mode_r = 0.
  - out_valid = 0, out_idx = 0, out_bit = 0.
  - busy = 0, done = 0, ones_count = 0, eval_out = 0.
- Reset mid-sweep: the sweep is abandoned, all registers return to their reset values the next cycle, and done is not pulsed.

## Timing
- eval_out has 1-cycle latency: eval_in sampled at edge k appears after edge k.
- start sampled at edge t:
  - out_valid = 1 with out_idx = 0 after edge t.
  - busy = 1 from that point until DONE ends.
- With out_ready held high, one beat transfers per cycle.
  - idx 0..2^N_IN-1 are presented in cycles t+1..t+2^N_IN.
  - done = 1 in cycle t+2^N_IN+1; busy drops after it.
- Back-pressure: while out_ready = 0, out_idx and out_bit hold stable and out_valid stays high.
- out_valid is 0 in IDLE and DONE.
- ones_count:
  - Final on the done cycle and held until the next start or reset.
  - Range 0..2^N_IN, with no overflow by construction.

## Configuration
- TRUTH_SWEEP_COUNT_EN
  - Defined: the ones_count accumulator is built as specified.
  - Undefined: no accumulator logic; ones_count is tied to 0. All other behaviour is identical.

## Structure
- Package truth_sweep_pkg contains:
  - state enum (IDLE, SWEEP, DONE);
  - constant MAX_N_IN = 6;
  - function term_value(mask, idx, mode), shared by the lookup and stream paths.
- Sub-module truth_lut holds the mask and mode registers and the registered eval_out lookup. The sweeper FSM instantiates it and reads through it.

## Test plan
- Reset, then lookup: after rst, any eval_in -> eval_out = 0. Load mask 8'h8E with mode 1, eval_in = 3'b100 -> eval_out = 1 one cycle later; eval_in = 3'b111 -> 0.
- Full-rate PoS sweep: mask 8'h8E, mode 1, out_ready = 1, start -> out_bit 1,0,0,0,1,1,1,0 at idx 0..7, done at t+9, ones_count = 4 (0 if TRUTH_SWEEP_COUNT_EN is undefined).
- SoP sweep with back-pressure: mask 8'h8E, mode 0, out_ready toggling 1,0 -> out_bit sequence 0,1,1,1,0,0,0,1, each beat held during stall cycles, ones_count = 4, done after 16 cycles.
- Ignored commands: start and load with mask 8'hFF during SWEEP -> stream unchanged, busy stays high; after done, a lookup still reflects 8'h8E.
- Simultaneous load and start in IDLE with mask 8'h01, mode 0 -> idx 0 beat out_bit = 1, remaining beats 0, ones_count = 1.
- Reset at idx 3 mid-sweep -> next cycle out_valid = 0, busy = 0, no done pulse; a subsequent sweep without a prior load yields all out_bit = 0 (mask cleared).
